// File: rtl/instr_decode_controller_if.sv
// Instruction-word / decoded-field bundle between the fetch side and the decode controller.
// The master presents in32; the slave returns the registered decode.
interface instr_decode_controller_if;
    logic [31:0] in32;
    logic        ri;
    logic [5:0]  rs;
    logic [5:0]  rd;
    logic [3:0]  fx;
    logic [5:0]  rt;
    logic [14:0] imm;
    logic [3:0]  ALUopsel;
    logic        WE1;
    logic        WE2;

    modport master (
        output in32,
        input  ri, rs, rd, fx, rt, imm, ALUopsel, WE1, WE2
    );

    modport slave (
        input  in32,
        output ri, rs, rd, fx, rt, imm, ALUopsel, WE1, WE2
    );
endinterface

// File: rtl/instr_decode_controller.sv
// Single-cycle instruction decoder: splits in32 into register/function/immediate fields
// and derives the ALU select and load/store write strobes, all registered with 1-cycle latency.
module instr_decode_controller #(
    parameter logic [3:0] LOAD_FX  = 4'b0100,
    parameter logic [3:0] STORE_FX = 4'b0011
) (
    input logic                        clk,
    input logic                        rst_n,
    instr_decode_controller_if.slave   bus
);

    logic        w_ri;
    logic [5:0]  w_rs;
    logic [5:0]  w_rd;
    logic [3:0]  w_fx;
    logic [5:0]  w_rt;
    logic [14:0] w_imm;
    logic        w_we1;
    logic        w_we2;

    logic        r_ri;
    logic [5:0]  r_rs;
    logic [5:0]  r_rd;
    logic [3:0]  r_fx;
    logic [5:0]  r_rt;
    logic [14:0] r_imm;
    logic [3:0]  r_alu_sel;
    logic        r_we1;
    logic        r_we2;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_ri  = bus.in32[31];
        w_rs  = bus.in32[30:25];
        w_rd  = bus.in32[24:19];
        w_fx  = bus.in32[18:15];
        w_rt  = 6'd0;
        w_imm = 15'd0;
        w_we1 = 1'b0;
        w_we2 = 1'b0;

        if (w_ri) begin
            w_imm = bus.in32[14:0];
        end else begin
            w_rt = bus.in32[14:9];
        end

        // An unknown fx fails the equality test, so the strobes stay low unless the code matches exactly.
        if (w_fx == LOAD_FX) begin
            w_we1 = 1'b1;
        end
        if (w_fx == STORE_FX) begin
            w_we2 = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers sample the same pre-edge values.
        if (!rst_n) begin
            r_ri      <= 1'b0;
            r_rs      <= 6'd0;
            r_rd      <= 6'd0;
            r_fx      <= 4'd0;
            r_rt      <= 6'd0;
            r_imm     <= 15'd0;
            r_alu_sel <= 4'd0;
            r_we1     <= 1'b0;
            r_we2     <= 1'b0;
        end else begin
            r_ri      <= w_ri;
            r_rs      <= w_rs;
            r_rd      <= w_rd;
            r_fx      <= w_fx;
            r_rt      <= w_rt;
            r_imm     <= w_imm;
            r_alu_sel <= w_fx;
            r_we1     <= w_we1;
            r_we2     <= w_we2;
        end
    end

    assign bus.ri       = r_ri;
    assign bus.rs       = r_rs;
    assign bus.rd       = r_rd;
    assign bus.fx       = r_fx;
    assign bus.rt       = r_rt;
    assign bus.imm      = r_imm;
    assign bus.ALUopsel = r_alu_sel;
    assign bus.WE1      = r_we1;
    assign bus.WE2      = r_we2;

endmodule

// File: tb/tb_instr_decode_controller.sv
// Directed, table-driven bench for instr_decode_controller plus reset and back-to-back sequences.
module tb_instr_decode_controller;

    typedef struct {
        string       name;
        logic [31:0] in32;
        logic        ri;
        logic [5:0]  rs;
        logic [5:0]  rd;
        logic [3:0]  fx;
        logic [5:0]  rt;
        logic [14:0] imm;
        logic [3:0]  alu;
        logic        we1;
        logic        we2;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_fail;
    vec_t vecs[10];

    instr_decode_controller_if bus ();

    instr_decode_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [43:0] pack_exp(input vec_t v);
        return {v.ri, v.rs, v.rd, v.fx, v.rt, v.imm, v.alu, v.we1, v.we2};
    endfunction

    function automatic logic [43:0] pack_act();
        return {bus.ri, bus.rs, bus.rd, bus.fx, bus.rt, bus.imm, bus.ALUopsel, bus.WE1, bus.WE2};
    endfunction

    task automatic check(input string name, input logic [43:0] act, input logic [43:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {ri,rs,rd,fx,rt,imm,alu,we1,we2}=%h want %h", name, act, exp);
        end
    endtask

    task automatic apply_and_check(input vec_t v);
        @(negedge clk);
        bus.in32 = v.in32;
        @(posedge clk);
        #1;
        check(v.name, pack_act(), pack_exp(v));
    endtask

    initial begin
        n_vec  = 0;
        n_fail = 0;

        vecs[0] = '{"i_form",     32'b1_011110_101010_1000_111111000000000,
                    1'b1, 6'b011110, 6'b101010, 4'b1000, 6'b000000, 15'b111111000000000, 4'b1000, 1'b0, 1'b0};
        vecs[1] = '{"r_form",     32'b0_111101_010101_0000_111111_000000000,
                    1'b0, 6'b111101, 6'b010101, 4'b0000, 6'b111111, 15'd0, 4'b0000, 1'b0, 1'b0};
        vecs[2] = '{"store_r",    32'b0_000110_000000_0011_000010_100000000,
                    1'b0, 6'b000110, 6'b000000, 4'b0011, 6'b000010, 15'd0, 4'b0011, 1'b0, 1'b1};
        vecs[3] = '{"load_r",     32'b0_000110_000110_0100_000000_000000000,
                    1'b0, 6'b000110, 6'b000110, 4'b0100, 6'b000000, 15'd0, 4'b0100, 1'b1, 1'b0};
        vecs[4] = '{"load_i",     32'b1_000001_000010_0100_101010101010101,
                    1'b1, 6'b000001, 6'b000010, 4'b0100, 6'b000000, 15'b101010101010101, 4'b0100, 1'b1, 1'b0};
        vecs[5] = '{"store_i",    32'b1_111111_111111_0011_111111111111111,
                    1'b1, 6'b111111, 6'b111111, 4'b0011, 6'b000000, 15'h7FFF, 4'b0011, 1'b0, 1'b1};
        vecs[6] = '{"r_low_bits", 32'b0_101010_010101_1111_110011_111111111,
                    1'b0, 6'b101010, 6'b010101, 4'b1111, 6'b110011, 15'd0, 4'b1111, 1'b0, 1'b0};
        vecs[7] = '{"fx_0101",    32'b0_000000_000000_0101_000000_000000000,
                    1'b0, 6'b000000, 6'b000000, 4'b0101, 6'b000000, 15'd0, 4'b0101, 1'b0, 1'b0};
        vecs[8] = '{"all_ones",   32'hFFFF_FFFF,
                    1'b1, 6'b111111, 6'b111111, 4'b1111, 6'b000000, 15'h7FFF, 4'b1111, 1'b0, 1'b0};
        vecs[9] = '{"all_zero",   32'h0000_0000,
                    1'b0, 6'b000000, 6'b000000, 4'b0000, 6'b000000, 15'd0, 4'b0000, 1'b0, 1'b0};

        // Reset held with an all-ones instruction: outputs must stay zero across edges.
        rst_n    = 1'b0;
        bus.in32 = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", pack_act(), 44'd0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_no_edge", pack_act(), 44'd0);
        @(posedge clk);
        #1;
        check("first_decode", pack_act(), pack_exp(vecs[8]));

        for (int i = 0; i < 10; i++) begin
            apply_and_check(vecs[i]);
        end

        // Constant input holds the decode across a further edge.
        @(posedge clk);
        #1;
        check("hold", pack_act(), pack_exp(vecs[9]));

        // Store then load on consecutive edges, then asynchronous reset between edges.
        apply_and_check(vecs[2]);
        apply_and_check(vecs[3]);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_mid", pack_act(), 44'd0);
        @(negedge clk);
        bus.in32 = vecs[0].in32;
        #2;
        rst_n = 1'b1;
        #1;
        check("still_zero_pre_edge", pack_act(), 44'd0);
        @(posedge clk);
        #1;
        check("decode_after_reset", pack_act(), pack_exp(vecs[0]));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
